alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single combinational `alu` (operands in1/in2, 4-bit alu_ctrl, result res, zero flag z_flg) between two requesters.
- Requester 0 is the execute-stage integer path; requester 1 is the branch/address-generation path.
- Each requester uses a valid/ready handshake. Grants are round-robin. The ALU result and zero flag are registered into one output slot, tagged with the requester ID and offered on a valid/ready response channel.
- Sits between the issue logic and writeback/branch resolution in the RISC-V core.

Parameters:
- DATA_W, 32, operand and result width.
- OP_W, 4, ALU operation code width (matches alu_ctrl).

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a  input  DATA_W  requester 0 operand 1
- req0_b  input  DATA_W  requester 0 operand 2
- req0_op  input  OP_W  requester 0 ALU control code
- req1_valid  input  1  requester 1 has an operation
- req1_ready  output  1  requester 1 operation accepted this cycle
- req1_a  input  DATA_W  requester 1 operand 1
- req1_b  input  DATA_W  requester 1 operand 2
- req1_op  input  OP_W  requester 1 ALU control code
- rsp_valid  output  1  output slot holds a result
- rsp_ready  input  1  consumer takes the result this cycle
- rsp_data  output  DATA_W  registered ALU result
- rsp_zero  output  1  registered ALU zero flag
- rsp_id  output  1  requester that issued the held result
- prio_o  output  1  current round-robin priority (debug)

Behaviour:
- Reset: clk and rst only; rst is synchronous and active-high. While rst=1 at a clock edge, set rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_id=0, prio=0.
- Reset mid-operation: a held, unconsumed result is discarded. req*_ready is forced to 0 while rst=1.
- Slot state: one bit, EMPTY (rsp_valid=0) or FULL (rsp_valid=1).
- can_accept = !rsp_valid || rsp_ready, giving full throughput: a new operation is accepted in the same cycle the held result is consumed.
- Grant selection (combinational, within the cycle):
  - Only one valid: grant that requester.
  - Both valid: grant the requester equal to prio.
  - Neither valid: no grant.
- reqN_ready = can_accept && grant==N && reqN_valid && !rst. Ready is never asserted to an idle requester.
- Operand mux: the granted requester's a/b/op drive the alu instance. With no grant the mux selects requester 0; the result is ignored.
- Handshake: on a cycle with reqN_valid && reqN_ready, capture at the edge rsp_data<=res, rsp_zero<=z_flg, rsp_id<=N, rsp_valid<=1.
- Latency: exactly 1 cycle from request handshake to rsp_valid=1.
- Result hold: while rsp_valid && !rsp_ready, rsp_data/rsp_zero/rsp_id stay stable. Both req*_ready stay 0 (backpressure).
- Consume without refill: rsp_ready && rsp_valid with no new grant sets rsp_valid<=0. Data registers retain their last value.
- Priority update: only on a request handshake. prio <= ~granted_id, so the other requester wins the next tie. Without a handshake, prio is unchanged.
- Starvation: with both valid continuously and rsp_ready=1, grants alternate 0,1,0,1. No requester waits more than 2 accepts.
- Requesters must hold a/b/op stable while valid && !ready. The block does not check this.
- Op codes: passed unmodified to alu. Codes with no defined operation return the alu default result. No error is flagged.
- Width: results are DATA_W bits with wrap-around, no carry or overflow output. rsp_zero is the alu z_flg, registered alongside the result.

Decomposition:
- Shared package alu_pkg holds:
  - the ALU operation code constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ... with encodings identical to those decoded by alu);
  - OP_W;
  - requester ID constants REQ_EXEC=0, REQ_BRANCH=1.
- Sub-module: instantiate the existing alu unmodified as the single shared datapath (instance u_alu).
- Arbitration (grant and prio) stays in this module; no separate arbiter module.

Test Plan:
- Single request: rst then release. req0 a=5, b=6, op=ALU_ADD with rsp_ready=1 -> req0_ready=1 same cycle; next cycle rsp_valid=1, rsp_data=11, rsp_zero=0, rsp_id=0.
- Zero flag: req1 a=7, b=7, op=ALU_SUB -> rsp_data=0, rsp_zero=1, rsp_id=1.
- Tie-break: both requests held valid for 4 cycles, req0 ADD 1+1, req1 ADD 2+2, rsp_ready=1 -> rsp_id sequence 0,1,0,1; rsp_data 2,4,2,4; prio_o toggles each cycle.
- Backpressure: result held with rsp_ready=0 for 3 cycles while both requests are valid -> req0_ready=req1_ready=0 and rsp_data stable. When rsp_ready rises, a new accept happens in the same cycle and rsp_valid stays 1 with the new data on the next cycle.
- Reset mid-operation: rsp_valid=1 held and unconsumed, assert rst for 1 cycle -> rsp_valid=0, rsp_data=0, prio_o=0; no ready during reset. The first accept after reset goes to req0 on a tie.
- Back-to-back single requester: req1 valid 3 consecutive cycles with rsp_ready=1 -> 3 accepts in 3 cycles, results 1 cycle later each; prio_o=0 after each accept.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU datapath and the ALU arbiter:
//   - OP_W            : ALU operation code width (matches alu_ctrl)
//   - ALU_* constants : operation encodings decoded by alu
//   - REQ_EXEC/BRANCH : requester IDs used by alu_arbiter
//   - slot_state_e    : state of the arbiter's single output slot
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int OP_W = 4;

    // ALU operation encodings; alu decodes exactly these values and returns
    // zero for any other code.
    localparam logic [OP_W-1:0] ALU_ADD  = 4'h0;
    localparam logic [OP_W-1:0] ALU_SUB  = 4'h1;
    localparam logic [OP_W-1:0] ALU_AND  = 4'h2;
    localparam logic [OP_W-1:0] ALU_OR   = 4'h3;
    localparam logic [OP_W-1:0] ALU_XOR  = 4'h4;
    localparam logic [OP_W-1:0] ALU_SLL  = 4'h5;
    localparam logic [OP_W-1:0] ALU_SRL  = 4'h6;
    localparam logic [OP_W-1:0] ALU_SRA  = 4'h7;
    localparam logic [OP_W-1:0] ALU_SLT  = 4'h8;
    localparam logic [OP_W-1:0] ALU_SLTU = 4'h9;

    // Requester identifiers
    localparam logic REQ_EXEC   = 1'b0;
    localparam logic REQ_BRANCH = 1'b1;

    // Output slot occupancy
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage : alu_pkg

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Purely combinational integer ALU.
// Ports:
//   in1, in2  : operands (DATA_W)
//   alu_ctrl  : operation code (OP_W), see alu_pkg ALU_* constants
//   res       : result, DATA_W bits with wrap-around
//   z_flg     : 1 when res is all zeros
// Undefined operation codes produce a zero result (and therefore z_flg=1).
// -----------------------------------------------------------------------------
module alu #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]        in1,
    input  logic [DATA_W-1:0]        in2,
    input  logic [alu_pkg::OP_W-1:0] alu_ctrl,
    output logic [DATA_W-1:0]        res,
    output logic                     z_flg
);
    import alu_pkg::*;

    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0] shamt_s;

    assign shamt_s = in2[SH_W-1:0];

    // Operation decode
    always_comb begin
        res = {DATA_W{1'b0}};
        case (alu_ctrl)
            ALU_ADD:  res = in1 + in2;
            ALU_SUB:  res = in1 - in2;
            ALU_AND:  res = in1 & in2;
            ALU_OR:   res = in1 | in2;
            ALU_XOR:  res = in1 ^ in2;
            ALU_SLL:  res = in1 << shamt_s;
            ALU_SRL:  res = in1 >> shamt_s;
            ALU_SRA:  res = $unsigned($signed(in1) >>> shamt_s);
            ALU_SLT:  res = {{(DATA_W-1){1'b0}}, ($signed(in1) < $signed(in2))};
            ALU_SLTU: res = {{(DATA_W-1){1'b0}}, (in1 < in2)};
            default:  res = {DATA_W{1'b0}};
        endcase
    end

    assign z_flg = (res == {DATA_W{1'b0}});

endmodule : alu

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational alu between two requesters (0 = execute path,
// 1 = branch/address-generation path) using round-robin arbitration. The
// granted operation's result and zero flag are captured into a single output
// slot tagged with the requester ID and offered on a valid/ready channel.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   reqN_valid/ready          : request handshake for requester N
//   reqN_a/b/op               : operands and ALU control of requester N
//   rsp_valid/ready           : response handshake
//   rsp_data/zero/id          : registered result, zero flag, requester ID
//   prio_o                    : current round-robin priority (debug)
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = alu_pkg::OP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic              rsp_id,
    output logic              prio_o
);
    import alu_pkg::*;

    slot_state_e       state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              zero_q, zero_d;
    logic              id_q, id_d;
    logic              prio_q, prio_d;

    logic              can_accept_s;
    logic              grant_vld_s;
    logic              grant_id_s;
    logic              accept_s;

    logic [DATA_W-1:0] alu_a_s;
    logic [DATA_W-1:0] alu_b_s;
    logic [OP_W-1:0]   alu_op_s;
    logic [DATA_W-1:0] alu_res_s;
    logic              alu_z_s;

    // A new operation fits when the slot is empty or is being drained now.
    assign can_accept_s = (state_q == SLOT_EMPTY) || rsp_ready;

    // Round-robin grant: a lone requester always wins, prio breaks ties
    always_comb begin
        grant_vld_s = 1'b0;
        grant_id_s  = REQ_EXEC;
        case ({req1_valid, req0_valid})
            2'b01: begin
                grant_vld_s = 1'b1;
                grant_id_s  = REQ_EXEC;
            end
            2'b10: begin
                grant_vld_s = 1'b1;
                grant_id_s  = REQ_BRANCH;
            end
            2'b11: begin
                grant_vld_s = 1'b1;
                grant_id_s  = prio_q;
            end
            default: begin
                grant_vld_s = 1'b0;
                grant_id_s  = REQ_EXEC;
            end
        endcase
    end

    assign accept_s   = can_accept_s && grant_vld_s && !rst;
    assign req0_ready = accept_s && (grant_id_s == REQ_EXEC);
    assign req1_ready = accept_s && (grant_id_s == REQ_BRANCH);

    // Operand mux; with no grant requester 0 drives the ALU and the result is unused
    always_comb begin
        if (grant_id_s == REQ_BRANCH) begin
            alu_a_s  = req1_a;
            alu_b_s  = req1_b;
            alu_op_s = req1_op;
        end else begin
            alu_a_s  = req0_a;
            alu_b_s  = req0_b;
            alu_op_s = req0_op;
        end
    end

    alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .in1      (alu_a_s),
        .in2      (alu_b_s),
        .alu_ctrl (alu_op_s),
        .res      (alu_res_s),
        .z_flg    (alu_z_s)
    );

    // Slot next-state: refill on accept, drain on consume, otherwise hold
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        zero_d  = zero_q;
        id_d    = id_q;
        prio_d  = prio_q;
        if (accept_s) begin
            state_d = SLOT_FULL;
            data_d  = alu_res_s;
            zero_d  = alu_z_s;
            id_d    = grant_id_s;
            prio_d  = ~grant_id_s;
        end else if ((state_q == SLOT_FULL) && rsp_ready) begin
            // Data registers keep their last value after the slot drains.
            state_d = SLOT_EMPTY;
        end else begin
            state_d = state_q;
        end
    end

    // Slot and priority registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= {DATA_W{1'b0}};
            zero_q  <= 1'b0;
            id_q    <= REQ_EXEC;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            id_q    <= id_d;
            prio_q  <= prio_d;
        end
    end

    assign rsp_valid = (state_q == SLOT_FULL);
    assign rsp_data  = data_q;
    assign rsp_zero  = zero_q;
    assign rsp_id    = id_q;
    assign prio_o    = prio_q;

endmodule : alu_arbiter

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench: a behavioural model of the arbiter (slot contents,
// round-robin priority, ALU arithmetic) is compared with the DUT every cycle,
// with directed scenarios pinned by literal expectations followed by a
// randomized phase.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req0_ready;
    logic [DATA_W-1:0] req0_a, req0_b;
    logic [OP_W-1:0]   req0_op;
    logic              req1_valid, req1_ready;
    logic [DATA_W-1:0] req1_a, req1_b;
    logic [OP_W-1:0]   req1_op;
    logic              rsp_valid, rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_zero, rsp_id, prio_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    bit          m_valid;
    logic [31:0] m_data;
    bit          m_zero;
    bit          m_id;
    bit          m_prio;
    bit          last_acc0, last_acc1;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
        .rsp_id     (rsp_id),
        .prio_o     (prio_o)
    );

    function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return a & b;
            4'h3:    return a | b;
            4'h4:    return a ^ b;
            4'h5:    return a << sh;
            4'h6:    return a >> sh;
            4'h7:    return $unsigned($signed(a) >>> sh);
            4'h8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h9:    return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Drive-then-compare for one clock: inputs are already applied just after
    // the previous rising edge; readies and registered outputs are checked
    // against the model, then the model advances across the edge.
    task automatic cycle();
        bit both, any, g, can, r0, r1;
        logic [31:0] res;
        #1;
        any  = req0_valid || req1_valid;
        both = req0_valid && req1_valid;
        g    = both ? m_prio : req1_valid;
        can  = !m_valid || rsp_ready;
        r0   = !rst && can && any && !g && req0_valid;
        r1   = !rst && can && any && g && req1_valid;
        chk("req0_ready", req0_ready, r0);
        chk("req1_ready", req1_ready, r1);
        chk("rsp_valid", rsp_valid, m_valid);
        chk("rsp_data", rsp_data, m_data);
        chk("rsp_zero", rsp_zero, m_zero);
        chk("rsp_id", rsp_id, m_id);
        chk("prio_o", prio_o, m_prio);
        last_acc0 = r0;
        last_acc1 = r1;
        if (rst) begin
            m_valid = 0; m_data = 32'd0; m_zero = 0; m_id = 0; m_prio = 0;
        end else if (r0 || r1) begin
            res     = g ? ref_alu(req1_op, req1_a, req1_b) : ref_alu(req0_op, req0_a, req0_b);
            m_valid = 1;
            m_data  = res;
            m_zero  = (res == 32'd0);
            m_id    = g;
            m_prio  = !g;
        end else if (m_valid && rsp_ready) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input bit v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    endtask

    task automatic set1(input bit v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] ra;
        rst = 1'b1;
        rsp_ready = 1'b1;
        set0(0, 32'd0, 32'd0, ALU_ADD);
        set1(0, 32'd0, 32'd0, ALU_ADD);
        @(posedge clk);
        #1;
        m_valid = 0; m_data = 32'd0; m_zero = 0; m_id = 0; m_prio = 0;
        cycle();
        chk("reset_valid", rsp_valid, 32'd0);
        chk("reset_prio", prio_o, 32'd0);
        rst = 1'b0;

        // Single request on requester 0
        set0(1, 32'd5, 32'd6, ALU_ADD);
        #1 chk("single_ready", req0_ready, 32'd1);
        cycle();
        set0(0, 32'd0, 32'd0, ALU_ADD);
        chk("single_valid", rsp_valid, 32'd1);
        chk("single_data", rsp_data, 32'd11);
        chk("single_zero", rsp_zero, 32'd0);
        chk("single_id", rsp_id, 32'd0);
        cycle();

        // Zero flag on requester 1
        set1(1, 32'd7, 32'd7, ALU_SUB);
        cycle();
        set1(0, 32'd0, 32'd0, ALU_ADD);
        chk("zero_data", rsp_data, 32'd0);
        chk("zero_flag", rsp_zero, 32'd1);
        chk("zero_id", rsp_id, 32'd1);
        cycle();

        // Tie-break alternation from a fresh priority
        do_reset();
        set0(1, 32'd1, 32'd1, ALU_ADD);
        set1(1, 32'd2, 32'd2, ALU_ADD);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("tie_id", rsp_id, (i % 2));
            chk("tie_data", rsp_data, (i % 2) ? 32'd4 : 32'd2);
            chk("tie_prio", prio_o, ((i + 1) % 2));
        end

        // Backpressure with both still requesting
        rsp_ready = 1'b0;
        held = rsp_data;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready0", req0_ready, 32'd0);
            chk("bp_ready1", req1_ready, 32'd0);
            cycle();
            chk("bp_data", rsp_data, held);
        end
        rsp_ready = 1'b1;
        #1 chk("bp_release_ready0", req0_ready, 32'd1);
        cycle();
        chk("bp_refill_valid", rsp_valid, 32'd1);
        chk("bp_refill_data", rsp_data, 32'd2);

        // Reset while a result is held
        rsp_ready = 1'b0;
        cycle();
        rst = 1'b1;
        #1;
        chk("rst_ready0", req0_ready, 32'd0);
        chk("rst_ready1", req1_ready, 32'd0);
        cycle();
        rst = 1'b0;
        chk("rst_valid", rsp_valid, 32'd0);
        chk("rst_data", rsp_data, 32'd0);
        chk("rst_prio", prio_o, 32'd0);
        rsp_ready = 1'b1;
        cycle();
        chk("rst_first_id", rsp_id, 32'd0);

        // Back-to-back single requester 1
        set0(0, 32'd0, 32'd0, ALU_ADD);
        for (int i = 0; i < 3; i++) begin
            set1(1, 32'd10 + i, 32'd3, ALU_ADD);
            cycle();
            chk("b2b_id", rsp_id, 32'd1);
            chk("b2b_data", rsp_data, 32'd13 + i);
            chk("b2b_prio", prio_o, 32'd0);
        end
        set1(0, 32'd0, 32'd0, ALU_ADD);
        cycle();

        // Randomized traffic; operands held while a request waits
        last_acc0 = 1; last_acc1 = 1;
        for (int n = 0; n < 400; n++) begin
            if (!(req0_valid && !last_acc0)) begin
                ra = $urandom_range(0, 7);
                set0(($urandom % 4) != 0, ra,
                     (($urandom % 3) == 0) ? ra : $urandom,
                     4'($urandom_range(0, 15)));
            end
            if (!(req1_valid && !last_acc1)) begin
                ra = $urandom;
                set1(($urandom % 4) != 0, ra,
                     (($urandom % 3) == 0) ? ra : 32'($urandom_range(0, 40)),
                     4'($urandom_range(0, 15)));
            end
            rsp_ready = ($urandom % 3) != 0;
            rst = (($urandom % 60) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_alu_arbiter
